// File: rtl/aes_pkg.sv
// Shared AES constants, InvSubBytes FSM states and inverse S-box table.
// Provides inv_sbox(byte) for the lookup lanes.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_NBYTES  = 16;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } isb_state_t;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box lane, 8 -> 8 lookup.
// Ports: sbox_in (byte in), sbox_out (substituted byte).
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] sbox_in,
    output logic [AES_BYTE_W-1:0] sbox_out
);

    assign sbox_out = inv_sbox(sbox_in);

endmodule

// File: rtl/aes_inv_sub_bytes_seq.sv
// Iterative InvSubBytes: LANES bytes per clock, one block in flight.
// Ports: clk, reset (sync, high), in_valid/in_ready/state_isb_in,
// round_key_in (INV_SUB_BYTES_ARK_EN only), out_valid/out_ready/
// state_isb_out, busy. Macro INV_SUB_BYTES_ARK_EN fuses AddRoundKey.
module aes_inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] state_isb_in,
`ifdef INV_SUB_BYTES_ARK_EN
    input  logic [AES_BLOCK_W-1:0] round_key_in,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] state_isb_out,
    output logic                   busy
);

    localparam int NSTEP = AES_NBYTES / LANES;
    localparam int IDX_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NSTEP - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
          LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("LANES must be 1, 2, 4, 8 or 16");
    end

    isb_state_t             state;
    logic [IDX_W-1:0]       idx;
    logic [AES_BLOCK_W-1:0] work;
    logic [AES_BLOCK_W-1:0] next_work;
    logic [AES_BLOCK_W-1:0] fin_work;
    logic [AES_BYTE_W-1:0]  lane_in  [LANES];
    logic [AES_BYTE_W-1:0]  lane_out [LANES];

`ifdef INV_SUB_BYTES_ARK_EN
    logic [AES_BLOCK_W-1:0] key_q;
`endif

    // Byte 0 sits in the MSBs, so byte p lives at [127-8p -: 8].
    always_comb begin
        int pos;
        for (int l = 0; l < LANES; l++) begin
            pos        = int'(idx) * LANES + l;
            lane_in[l] = work[AES_BLOCK_W-8-8*pos +: 8];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        aes_inv_sbox u_sbox (
            .sbox_in  (lane_in[g]),
            .sbox_out (lane_out[g])
        );
    end

    always_comb begin
        int pos;
        next_work = work;
        for (int l = 0; l < LANES; l++) begin
            pos = int'(idx) * LANES + l;
            next_work[AES_BLOCK_W-8-8*pos +: 8] = lane_out[l];
        end
    end

    // Last substitution step also applies the round key when fused.
`ifdef INV_SUB_BYTES_ARK_EN
    assign fin_work = next_work ^ key_q;
`else
    assign fin_work = next_work;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            work      <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef INV_SUB_BYTES_ARK_EN
            key_q     <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        work  <= state_isb_in;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= SUB;
`ifdef INV_SUB_BYTES_ARK_EN
                        key_q <= round_key_in;
`endif
                    end
                end
                SUB: begin
                    if (idx == LAST) begin
                        work      <= fin_work;
                        idx       <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        work <= next_work;
                        idx  <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready      = (state == IDLE) && !reset;
    assign state_isb_out = work;

endmodule

// File: tb/tb_aes_inv_sub_bytes_seq.sv
// Bench for aes_inv_sub_bytes_seq: LANES=1,4,16 instances.
// Table vectors plus backpressure, reset, back-to-back sequences.
module tb_aes_inv_sub_bytes_seq;

    localparam int NV = 7;
    localparam int NP = 9;

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
        logic [127:0] key;
    } vec_t;

    typedef struct {
        int           k;
        logic [127:0] exp;
    } sb_t;

    logic         clk;
    logic         reset;
    logic         iv   [3];
    logic         ir   [3];
    logic         ov   [3];
    logic         ordy [3];
    logic         bz   [3];
    logic [127:0] din  [3];
    logic [127:0] dout [3];
    logic [127:0] key  [3];

    int   nstep [3];
    int   n_tests;
    int   n_fail;
    vec_t vt [NV];
    sb_t  sbq [$];

    logic [7:0] pin  [NP];
    logic [7:0] pout [NP];

    aes_inv_sub_bytes_seq #(.LANES(1)) u_l1 (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (iv[0]),
        .in_ready      (ir[0]),
        .state_isb_in  (din[0]),
`ifdef INV_SUB_BYTES_ARK_EN
        .round_key_in  (key[0]),
`endif
        .out_valid     (ov[0]),
        .out_ready     (ordy[0]),
        .state_isb_out (dout[0]),
        .busy          (bz[0])
    );

    aes_inv_sub_bytes_seq #(.LANES(4)) u_l4 (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (iv[1]),
        .in_ready      (ir[1]),
        .state_isb_in  (din[1]),
`ifdef INV_SUB_BYTES_ARK_EN
        .round_key_in  (key[1]),
`endif
        .out_valid     (ov[1]),
        .out_ready     (ordy[1]),
        .state_isb_out (dout[1]),
        .busy          (bz[1])
    );

    aes_inv_sub_bytes_seq #(.LANES(16)) u_l16 (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (iv[2]),
        .in_ready      (ir[2]),
        .state_isb_in  (din[2]),
`ifdef INV_SUB_BYTES_ARK_EN
        .round_key_in  (key[2]),
`endif
        .out_valid     (ov[2]),
        .out_ready     (ordy[2]),
        .state_isb_out (dout[2]),
        .busy          (bz[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [127:0] expv(input vec_t v);
`ifdef INV_SUB_BYTES_ARK_EN
        return v.dout ^ v.key;
`else
        return v.dout;
`endif
    endfunction

    task automatic check(input string name,
                         input logic [127:0] act,
                         input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    task automatic pop_check(input int k, input string name);
        sb_t e;
        if (sbq.size() == 0) begin
            fail_now({name, "_sb_empty"});
            return;
        end
        e = sbq.pop_front();
        if (e.k != k) fail_now({name, "_sb_inst"});
        check(name, dout[k], e.exp);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input int k, input vec_t v, output bit ok);
        int t;
        t      = 0;
        din[k] = v.din;
        key[k] = v.key;
        iv[k]  = 1'b1;
        while (!ir[k] && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!ir[k]) begin
            fail_now($sformatf("accept_timeout_k%0d", k));
            iv[k] = 1'b0;
            ok    = 1'b0;
            return;
        end
        sbq.push_back('{k, expv(v)});
        @(posedge clk);
        @(negedge clk);
        iv[k]  = 1'b0;
        din[k] = {$urandom, $urandom, $urandom, $urandom};
        key[k] = {$urandom, $urandom, $urandom, $urandom};
        ok     = 1'b1;
    endtask

    task automatic wait_valid(input int k, input string name,
                              output bit ok);
        int lat;
        lat = 0;
        check({name, "_busy"}, bz[k], 1);
        while (!ov[k] && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (!ov[k]) begin
            fail_now({name, "_valid_timeout"});
            ok = 1'b0;
            return;
        end
        check({name, "_latency"}, lat, nstep[k]);
        ok = 1'b1;
    endtask

    task automatic release_out(input int k, input string name);
        ordy[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy[k] = 1'b0;
        check({name, "_ov_after"}, ov[k], 0);
        check({name, "_ir_after"}, ir[k], 1);
    endtask

    initial begin
        bit   ok;
        vec_t bv;
        n_tests  = 0;
        n_fail   = 0;
        nstep[0] = 16;
        nstep[1] = 4;
        nstep[2] = 1;
        pin  = '{8'h63, 8'h7c, 8'h16, 8'h00, 8'h01,
                 8'hff, 8'h52, 8'h77, 8'h7b};
        pout = '{8'h00, 8'h01, 8'hff, 8'h52, 8'h09,
                 8'h7d, 8'h48, 8'h02, 8'h03};

        vt[0].din  = {16{8'h63}};
        vt[0].dout = {16{8'h00}};
        vt[0].key  = '0;
        vt[1].din  = {4{32'h637c1600}};
        vt[1].dout = {4{32'h0001ff52}};
        vt[1].key  = '0;
        for (int i = 0; i < 16; i++) begin
            vt[2].din[127-8*i -: 8]  = pin[i % NP];
            vt[2].dout[127-8*i -: 8] = pout[i % NP];
            vt[3].din[127-8*i -: 8]  = pin[(i*4+3) % NP];
            vt[3].dout[127-8*i -: 8] = pout[(i*4+3) % NP];
            vt[4].din[127-8*i -: 8]  = pin[((15-i)*2) % NP];
            vt[4].dout[127-8*i -: 8] = pout[((15-i)*2) % NP];
        end
        vt[2].key  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        vt[3].key  = '0;
        vt[4].key  = {16{8'h5a}};
        vt[5].din  = {16{8'h63}};
        vt[5].dout = {16{8'h00}};
        vt[5].key  = {16{8'hff}};
        vt[6].din  = {16{8'h63}};
        vt[6].dout = {16{8'h00}};
        vt[6].key  = '0;

        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            iv[k]   = 1'b0;
            ordy[k] = 1'b0;
            din[k]  = '0;
            key[k]  = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_ir_k%0d", k), ir[k], 0);
            check($sformatf("rst_ov_k%0d", k), ov[k], 0);
            check($sformatf("rst_busy_k%0d", k), bz[k], 0);
            check($sformatf("rst_dout_k%0d", k), dout[k], 0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Table vectors through every lane width.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NV; i++) begin
                string nm;
                nm = $sformatf("vec_k%0d_v%0d", k, i);
                send(k, vt[i], ok);
                if (!ok) continue;
                wait_valid(k, nm, ok);
                if (!ok) begin
                    void'(sbq.pop_front());
                    continue;
                end
                pop_check(k, nm);
                release_out(k, nm);
            end
        end

        // Backpressure on the LANES=4 instance.
        send(1, vt[2], ok);
        wait_valid(1, "bp", ok);
        if (ok) begin
            for (int c = 0; c < 5; c++) begin
                iv[1]  = 1'b1;
                din[1] = vt[3].din;
                key[1] = vt[3].key;
                check($sformatf("bp_ov_c%0d", c), ov[1], 1);
                check($sformatf("bp_ir_c%0d", c), ir[1], 0);
                check($sformatf("bp_data_c%0d", c), dout[1], expv(vt[2]));
                @(posedge clk);
                @(negedge clk);
            end
            iv[1] = 1'b0;
            pop_check(1, "bp_data");
            release_out(1, "bp");
            check("bp_busy_after", bz[1], 0);
            repeat (6) @(negedge clk);
            check("bp_no_extra_ov", ov[1], 0);
            check("bp_no_capture", bz[1], 0);
        end else begin
            void'(sbq.pop_front());
        end

        // Reset during the second SUB cycle.
        send(1, vt[3], ok);
        if (ok) begin
            void'(sbq.pop_back());
            @(posedge clk);
            @(negedge clk);
            reset = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("rst_mid_ov", ov[1], 0);
            check("rst_mid_dout", dout[1], 0);
            check("rst_mid_busy", bz[1], 0);
            check("rst_mid_ir", ir[1], 0);
            iv[1]  = 1'b1;
            din[1] = vt[4].din;
            @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            iv[1] = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("rst_iv_busy", bz[1], 0);
            begin
                int seen;
                seen = 0;
                for (int c = 0; c < 20; c++) begin
                    if (ov[1]) seen++;
                    @(negedge clk);
                end
                check("rst_no_output", seen, 0);
            end
            send(1, vt[4], ok);
            wait_valid(1, "rst_next", ok);
            if (ok) begin
                pop_check(1, "rst_next");
                release_out(1, "rst_next");
            end else begin
                void'(sbq.pop_front());
            end
        end

        // Back-to-back with in_valid and out_ready held high.
        begin
            int acc;
            int last;
            bit take;
            acc     = 0;
            last    = -1;
            bv      = vt[0];
            din[1]  = bv.din;
            key[1]  = bv.key;
            iv[1]   = 1'b1;
            ordy[1] = 1'b1;
            for (int c = 0; c < 40; c++) begin
                take = ir[1];
                if (ov[1]) pop_check(1, $sformatf("b2b_out_c%0d", c));
                if (take) begin
                    sbq.push_back('{1, expv(bv)});
                    if (last >= 0)
                        check($sformatf("b2b_gap_c%0d", c), c - last, 6);
                    last = c;
                    acc++;
                end
                @(posedge clk);
                @(negedge clk);
                if (take) begin
                    bv     = vt[acc % NV];
                    din[1] = bv.din;
                    key[1] = bv.key;
                end
            end
            iv[1] = 1'b0;
            check("b2b_accepts", acc, 7);
            for (int c = 0; c < 20 && sbq.size() > 0; c++) begin
                if (ov[1]) pop_check(1, $sformatf("b2b_drain_c%0d", c));
                @(posedge clk);
                @(negedge clk);
            end
            ordy[1] = 1'b0;
            check("b2b_sb_empty", sbq.size(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
